restoring_divider: RTL and testbench

//  Sequential unsigned restoring divider: out_quot = in_a / in_b, out_rem = in_a % in_b.

---
 rtl/restoring_divider_pkg.sv | 18 +
 rtl/rippleborrowsubtractor.sv | 24 ++
 rtl/restoring_divider.sv | 99 +++++++++
 tb/tb_restoring_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_div_state;

  localparam int DIV_BITS = 16;

  function automatic int ctr_width(input int bits);
    return $clog2(bits) + 1;
  endfunction

  localparam int DIV_CTR_W = ctr_width(DIV_BITS);

endpackage

// File: rtl/rippleborrowsubtractor.sv
// Ripple-borrow subtractor: diff = a - b modulo 2**BITS, one full subtractor per bit.
module rippleborrowsubtractor #(
  parameter int BITS = 17
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] diff
);

  // borrow_in[i] is the borrow flowing into bit i; bit 0 never borrows.
  logic [BITS-1:0] borrow_in;

  assign borrow_in[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < BITS; gi++) begin : g_bit
      assign diff[gi] = a[gi] ^ b[gi] ^ borrow_in[gi];
      if (gi < BITS - 1) begin : g_borrow
        assign borrow_in[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow_in[gi]);
      end
    end
  endgenerate

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction and one quotient bit per clock.
module restoring_divider
  import div_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  output logic [BITS-1:0] out_quot,
  output logic [BITS-1:0] out_rem,
  output logic            out_busy,
  output logic            out_finished,
  output logic            out_divzero
);

  localparam int CW = ctr_width(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  t_div_state      state;
  logic [CW-1:0]   ctr;
  logic [BITS-1:0] a_reg;
  logic [BITS-1:0] b_reg;
  logic [BITS-1:0] rem_reg;
  logic [BITS-1:0] quot_reg;
  logic            divzero_reg;
  logic            busy_reg;
  logic            finished_reg;

  logic [BITS:0]   shifted;
  logic [BITS:0]   diff;
  logic            q_bit;

  // rem_reg < b_reg holds at rest, so BITS bits suffice; only the trial value needs BITS+1.
  assign shifted = {rem_reg, a_reg[BITS-1]};

  rippleborrowsubtractor #(.BITS(BITS + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, b_reg}),
    .diff (diff)
  );

  assign q_bit = ~diff[BITS];

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state        <= IDLE;
      ctr          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      divzero_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finished_reg <= 1'b0;
          if (in_start) begin
            a_reg       <= in_a;
            b_reg       <= in_b;
            rem_reg     <= '0;
            quot_reg    <= '0;
            ctr         <= '0;
            divzero_reg <= (in_b == '0);
            busy_reg    <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          a_reg    <= a_reg << 1;
          rem_reg  <= q_bit ? diff[BITS-1:0] : shifted[BITS-1:0];
          quot_reg <= {quot_reg[BITS-2:0], q_bit};
          ctr      <= ctr + 1'b1;
          if (ctr == LAST) begin
            state        <= DONE;
            finished_reg <= 1'b1;
          end
        end
        DONE: begin
          busy_reg     <= 1'b0;
          finished_reg <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_quot     = quot_reg;
  assign out_rem      = rem_reg;
  assign out_busy     = busy_reg;
  assign out_finished = finished_reg;
  assign out_divzero  = divzero_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider against a reference quotient/remainder model.
module tb_restoring_divider;

  localparam int BITS = 16;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b0;
  logic            in_start = 1'b0;
  logic [BITS-1:0] in_a = '0;
  logic [BITS-1:0] in_b = '0;
  logic [BITS-1:0] out_quot;
  logic [BITS-1:0] out_rem;
  logic            out_busy;
  logic            out_finished;
  logic            out_divzero;

  typedef struct {
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            dz;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  restoring_divider #(.BITS(BITS)) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_start     (in_start),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_busy     (out_busy),
    .out_finished (out_finished),
    .out_divzero  (out_divzero)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called one step after a rising edge with the DUT idle; returns in the same phase, DUT idle again.
  task automatic do_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input bit intrude);
    exp_t e;
    int   cycles;
    int   busy_cnt;
    sb.push_back(model(a, b));
    in_a     = a;
    in_b     = b;
    in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    in_a     = ~a;
    in_b     = b + 16'd3;
    cycles   = 0;
    busy_cnt = 0;
    while (out_finished !== 1'b1 && cycles < 64) begin
      if (out_busy === 1'b1) busy_cnt++;
      if (intrude && cycles == 3) begin
        in_start = 1'b1;
        in_a     = 16'd50;
        in_b     = 16'd3;
      end
      if (intrude && cycles == 4) in_start = 1'b0;
      @(posedge in_clk); #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'(BITS));
    if (out_busy === 1'b1) busy_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("quot", 32'(out_quot), 32'(e.q));
      check("rem", 32'(out_rem), 32'(e.r));
      check("divzero", 32'(out_divzero), 32'(e.dz));
    end
    if (intrude) begin
      in_start = 1'b1;
      in_a     = 16'd9;
      in_b     = 16'd2;
    end
    @(posedge in_clk); #1;
    in_start = 1'b0;
    check("finished_pulse_len", 32'(out_finished), 32'd0);
    check("busy_after_done", 32'(out_busy), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(BITS + 1));
    check("quot_held", 32'(out_quot), 32'(e.q));
    if (intrude) begin
      @(posedge in_clk); #1;
      check("no_restart", 32'(out_busy), 32'd0);
    end
  endtask

  initial begin
    logic [BITS-1:0] ra;
    logic [BITS-1:0] rb;

    repeat (3) @(posedge in_clk);
    #1;
    check("rst_quot", 32'(out_quot), 32'd0);
    check("rst_rem", 32'(out_rem), 32'd0);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_finished", 32'(out_finished), 32'd0);
    check("rst_divzero", 32'(out_divzero), 32'd0);
    in_rst = 1'b1;
    @(posedge in_clk); #1;

    do_op(16'd234, 16'd123, 1'b0);
    do_op(16'hFFFF, 16'd1, 1'b0);
    do_op(16'd5, 16'd9, 1'b0);
    do_op(16'd7, 16'd0, 1'b0);
    do_op(16'd1000, 16'd7, 1'b1);
    do_op(16'd0, 16'd5, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0);

    // Abort a divide-by-zero operation mid-run with reset.
    in_a     = 16'h1234;
    in_b     = 16'd0;
    in_start = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    repeat (4) @(posedge in_clk);
    #1;
    check("mid_busy", 32'(out_busy), 32'd1);
    check("mid_divzero", 32'(out_divzero), 32'd1);
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    check("abort_busy", 32'(out_busy), 32'd0);
    check("abort_quot", 32'(out_quot), 32'd0);
    check("abort_rem", 32'(out_rem), 32'd0);
    check("abort_divzero", 32'(out_divzero), 32'd0);
    check("abort_finished", 32'(out_finished), 32'd0);
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    do_op(16'd100, 16'd10, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      do_op(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
